ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Parametrised successor of the current control decoder.
- Decodes the 16-bit instruction into a 16-bit control word and a 12-bit register field, and carries both down a STAGES-deep control pipeline.
- Adds features the current decoder lacks: per-stage valid bits, stall generation for RAW hazards and multi-cycle multiply, and flush (bubble insertion) for taken jumps/branches.
- Sits between instruction fetch and the datapath stages.

Parameters:
- STAGES, 3, number of pipeline stages including combinational stage 0; legal range ≥2.
- MUL_CYCLES, 4, cycles a mul (op 15) occupies stage 1; legal range ≥1.
- HAZARD_EN, 1, 1 enables RAW hazard stall; 0 ties the hazard term to 0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- inst  in  16  instruction: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0].
- inst_valid  in  1  inst is valid this cycle.
- flush  in  1  kill stage 0 and stage 1 at the next edge.
- stall  out  1  fetch must hold inst; equals hazard OR mul_busy, forced 0 while flush=1.
- mul_busy  out  1  mul occupying stage 1.
- ctrl_out  out  16*STAGES  stage k in bits [16k+15:16k].
- regs_out  out  12*STAGES  stage k in bits [12k+11:12k].
- valid_out  out  STAGES  valid bit per stage.

Behaviour:
- Control word bits:
  - 0 EscCondCP
  - 1 EscCP
  - 2 ULA_A
  - 4:3 ULA_B
  - 5 EscIR (always 0)
  - 7:6 FonteCP
  - 8 EscReg
  - 9 reserved (0)
  - 10 Mul
  - 14:11 op
  - 15 reserved (0)
- Decode (stage 0, combinational, zero latency):
  - op 0,1,3,4,5,13,14: EscCP=1, ULA_A=1, ULA_B=00, EscReg=1.
  - op 2,6–10: same as above but ULA_B=10.
  - op 11 (jump): EscCP=1, ULA_A=1, ULA_B=10, FonteCP=10, EscReg=0.
  - op 12 (branch): EscCondCP=1, EscCP=1, ULA_A=0, ULA_B=00, FonteCP=01, EscReg=0.
  - op 15 (mul): EscCP=0, ULA_A=1, ULA_B=00, EscReg=1, Mul=1.
  - Every bit not listed for an op is 0.
  - inst==16'h0000 decodes to control word 0.
- Stage 0 outputs:
  - regs_out stage 0 = inst[11:0].
  - valid_out[0] = inst_valid & ~flush.
  - ctrl_out/regs_out stage 0 are 0 whenever valid_out[0]=0.
- Bubble: ctrl=0, regs=0, valid=0.
- Reset: all registered stages (1..STAGES-1) take bubble values; mul counter=0; stall=0; mul_busy=0. Asynchronous assertion; reset mid-mul aborts it.
- Normal advance: each edge, stage k ← stage k-1 for k=1..STAGES-1.
- hazard (HAZARD_EN=1): valid_out[0] AND, for some stage j in 1..STAGES-1, valid_j & EscReg_j & rd_j≠0 & (rd_j==rs_0 | rd_j==rt_0). No dependency on op of stage 0.
- Mul counter:
  - Loads MUL_CYCLES-1 when a valid op-15 word enters stage 1.
  - Decrements while nonzero.
  - mul_busy = (cnt≠0).
  - MUL_CYCLES=1 never asserts mul_busy.
- Priority at each edge:
  1. flush: stage1 ← bubble; stage2 ← bubble (if STAGES>2); stages≥3 shift; cnt ← 0.
  2. mul_busy: stage1 holds; stage2 ← bubble; stages≥3 shift; stage 0 not consumed.
  3. hazard: stage1 ← bubble; stages≥2 shift; stage 0 not consumed.
  4. Otherwise: normal advance.
- A stall always holds stage 0 (fetch keeps inst); the held instruction is consumed on the first non-stall edge.
- Back-to-back muls: the second enters stage 1 only after the first leaves, then reloads the counter.

Test Plan:
- Decode sweep, one valid cycle each (stage 0 ctrl):
  - 0x1234 → 0x0906
  - 0x2345 → 0x1116
  - 0xB123 → 0x5896
  - 0xC456 → 0x6043
  - 0xF321 → 0x7D04
  - 0x0000 → 0x0000
  - Each word appears in stage 1 at +1 and stage 2 at +2 with valid set.
- Reset: hold rst_n=0 mid-stream → all registered stages, valid, stall, mul_busy read 0 immediately (asynchronous), before the next edge.
- RAW hazard, STAGES=3:
  - Stimulus: 0x1300 then 0x2034.
  - stall=1 for exactly 2 cycles; stage 1 shows two bubbles; 0x2034 enters stage 1 on the third edge.
  - Same sequence with HAZARD_EN=0 gives no stall.
- Mul, MUL_CYCLES=4:
  - Stimulus: 0xF321 then 0x1234.
  - mul_busy=1 for 3 cycles after mul enters stage 1; stage 2 receives 3 bubbles; 0x1234 reaches stage 1 on the 4th edge after the mul.
- Flush:
  - Stimulus: 0xB123 in stage 2, 0x1234 in stage 1, 0x2345 at stage 0, flush=1 for one cycle.
  - valid_out[0]=0 that cycle; next edge stages 1 and 2 are bubbles; stall=0.
- Flush during mul_busy: cnt clears; mul_busy drops the next cycle; the flush takes priority over the hold.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// Handshake bundle between instruction fetch and the control pipeline.
// The fetch side is the master; ctrl_pipe is the slave.
interface ctrl_pipe_if #(
    parameter int STAGES = 3
) ();
    logic [15:0]           inst;
    logic                  inst_valid;
    logic                  flush;
    logic                  stall;
    logic                  mul_busy;
    logic [16*STAGES-1:0]  ctrl_out;
    logic [12*STAGES-1:0]  regs_out;
    logic [STAGES-1:0]     valid_out;

    modport master (
        output inst, inst_valid, flush,
        input  stall, mul_busy, ctrl_out, regs_out, valid_out
    );

    modport slave (
        input  inst, inst_valid, flush,
        output stall, mul_busy, ctrl_out, regs_out, valid_out
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Instruction decoder feeding a STAGES-deep control pipeline.
// Stage 0 is combinational; it also generates RAW/multiply stalls and honours flush.
module ctrl_pipe #(
    parameter int STAGES     = 3,
    parameter int MUL_CYCLES = 4,
    parameter bit HAZARD_EN  = 1'b1
) (
    input logic        clk,
    input logic        rst_n,
    ctrl_pipe_if.slave bus
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [15:0] inst;
    logic [3:0]  op;
    logic [15:0] ctrl_dec;
    logic [15:0] ctrl0;
    logic [11:0] regs0;
    logic        valid0;
    logic        hazard;
    logic        mul_busy;
    logic        load_mul;
    logic [CW-1:0] cnt;

    logic [STAGES-1:1][15:0] ctrl_q;
    logic [STAGES-1:1][11:0] regs_q;
    logic [STAGES-1:1]       valid_q;

    assign inst = bus.inst;
    assign op   = inst[15:12];

    always_comb begin
        ctrl_dec = 16'h0000;
        unique case (op)
            4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd13, 4'd14: begin
                ctrl_dec[1] = 1'b1;
                ctrl_dec[2] = 1'b1;
                ctrl_dec[8] = 1'b1;
            end
            4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
                ctrl_dec[1]   = 1'b1;
                ctrl_dec[2]   = 1'b1;
                ctrl_dec[4:3] = 2'b10;
                ctrl_dec[8]   = 1'b1;
            end
            4'd11: begin
                ctrl_dec[1]   = 1'b1;
                ctrl_dec[2]   = 1'b1;
                ctrl_dec[4:3] = 2'b10;
                ctrl_dec[7:6] = 2'b10;
            end
            4'd12: begin
                ctrl_dec[0]   = 1'b1;
                ctrl_dec[1]   = 1'b1;
                ctrl_dec[7:6] = 2'b01;
            end
            default: begin
                ctrl_dec[2]  = 1'b1;
                ctrl_dec[8]  = 1'b1;
                ctrl_dec[10] = 1'b1;
            end
        endcase
        ctrl_dec[14:11] = op;
        // An all-zero instruction is a true nop, not an op-0 register write.
        if (inst == 16'h0000) begin
            ctrl_dec = 16'h0000;
        end
    end

    assign valid0 = bus.inst_valid & ~bus.flush;
    assign ctrl0  = valid0 ? ctrl_dec   : 16'h0000;
    assign regs0  = valid0 ? inst[11:0] : 12'h000;

    always_comb begin
        hazard = 1'b0;
        if (HAZARD_EN && valid0) begin
            for (int j = 1; j < STAGES; j++) begin
                if (valid_q[j] && ctrl_q[j][8] && (regs_q[j][11:8] != 4'd0) &&
                    ((regs_q[j][11:8] == inst[7:4]) || (regs_q[j][11:8] == inst[3:0]))) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    assign mul_busy = (cnt != '0);
    assign load_mul = valid0 & ctrl_dec[10] & ~mul_busy & ~hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            regs_q  <= '0;
            valid_q <= '0;
            cnt     <= '0;
        end else begin
            if (bus.flush) begin
                ctrl_q[1]  <= 16'h0000;
                regs_q[1]  <= 12'h000;
                valid_q[1] <= 1'b0;
            end else if (mul_busy) begin
                ctrl_q[1]  <= ctrl_q[1];
                regs_q[1]  <= regs_q[1];
                valid_q[1] <= valid_q[1];
            end else if (hazard) begin
                ctrl_q[1]  <= 16'h0000;
                regs_q[1]  <= 12'h000;
                valid_q[1] <= 1'b0;
            end else begin
                ctrl_q[1]  <= ctrl0;
                regs_q[1]  <= regs0;
                valid_q[1] <= valid0;
            end

            // Stage 2 is the only downstream stage affected by flush or a mul hold.
            for (int k = 2; k < STAGES; k++) begin
                if ((k == 2) && (bus.flush || mul_busy)) begin
                    ctrl_q[k]  <= 16'h0000;
                    regs_q[k]  <= 12'h000;
                    valid_q[k] <= 1'b0;
                end else begin
                    ctrl_q[k]  <= ctrl_q[k-1];
                    regs_q[k]  <= regs_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                end
            end

            if (bus.flush) begin
                cnt <= '0;
            end else if (load_mul) begin
                cnt <= CW'(MUL_CYCLES - 1);
            end else if (mul_busy) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign bus.mul_busy  = mul_busy;
    assign bus.stall     = (hazard | mul_busy) & ~bus.flush;
    assign bus.ctrl_out  = {ctrl_q, ctrl0};
    assign bus.regs_out  = {regs_q, regs0};
    assign bus.valid_out = {valid_q, valid0};
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: one DUT with RAW stalls enabled, one without,
// both fed the same fetch stream.
module tb_ctrl_pipe;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    ctrl_pipe_if #(.STAGES(3)) bus_a ();
    ctrl_pipe_if #(.STAGES(3)) bus_b ();

    ctrl_pipe #(.STAGES(3), .MUL_CYCLES(4), .HAZARD_EN(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    ctrl_pipe #(.STAGES(3), .MUL_CYCLES(4), .HAZARD_EN(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] i, input logic v, input logic f);
        bus_a.inst = i;  bus_a.inst_valid = v;  bus_a.flush = f;
        bus_b.inst = i;  bus_b.inst_valid = v;  bus_b.flush = f;
        #1;
    endtask

    logic [15:0] dec_inst [6] = '{16'h1234, 16'h2345, 16'hB123, 16'hC456, 16'hF321, 16'h0000};
    logic [15:0] dec_exp  [6] = '{16'h0906, 16'h1116, 16'h5896, 16'h6043, 16'h7D04, 16'h0000};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        drive(16'h0000, 1'b0, 1'b0);
        repeat (2) tick();
        chk("rst_valid", 32'(bus_a.valid_out), 32'h0);
        chk("rst_ctrl",  32'(bus_a.ctrl_out[47:16]), 32'h0);
        chk("rst_stall", 32'(bus_a.stall), 32'h0);
        chk("rst_mulb",  32'(bus_a.mul_busy), 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Decode sweep: each word alone in an otherwise empty pipe.
        for (int w = 0; w < 6; w++) begin
            drive(dec_inst[w], 1'b1, 1'b0);
            chk("dec_s0_ctrl", 32'(bus_a.ctrl_out[15:0]), 32'(dec_exp[w]));
            chk("dec_s0_regs", 32'(bus_a.regs_out[11:0]), 32'(dec_inst[w][11:0]));
            chk("dec_s0_vld",  32'(bus_a.valid_out[0]), 32'h1);
            tick();
            drive(16'h0000, 1'b0, 1'b0);
            chk("dec_s1_ctrl", 32'(bus_a.ctrl_out[31:16]), 32'(dec_exp[w]));
            chk("dec_s1_vld",  32'(bus_a.valid_out[1]), 32'h1);
            tick();
            // A mul is held in stage 1, so stage 2 sees a bubble instead.
            if (dec_inst[w][15:12] == 4'hF) begin
                chk("dec_s2_ctrl", 32'(bus_a.ctrl_out[47:32]), 32'h0);
                chk("dec_s2_vld",  32'(bus_a.valid_out[2]), 32'h0);
            end else begin
                chk("dec_s2_ctrl", 32'(bus_a.ctrl_out[47:32]), 32'(dec_exp[w]));
                chk("dec_s2_vld",  32'(bus_a.valid_out[2]), 32'h1);
            end
            repeat (5) tick();
        end

        // RAW hazard: 0x1300 writes r3, 0x2034 reads r3.
        drive(16'h1300, 1'b1, 1'b0);
        tick();
        drive(16'h2034, 1'b1, 1'b0);
        chk("haz_stall_c1", 32'(bus_a.stall), 32'h1);
        chk("haz_off_stall", 32'(bus_b.stall), 32'h0);
        tick();
        chk("haz_stall_c2", 32'(bus_a.stall), 32'h1);
        chk("haz_s1_bub1",  32'(bus_a.valid_out[1]), 32'h0);
        chk("haz_off_s1",   32'(bus_b.ctrl_out[31:16]), 32'h1116);
        tick();
        chk("haz_stall_c3", 32'(bus_a.stall), 32'h0);
        chk("haz_s1_bub2",  32'(bus_a.valid_out[1]), 32'h0);
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        chk("haz_s1_ctrl", 32'(bus_a.ctrl_out[31:16]), 32'h1116);
        chk("haz_s1_regs", 32'(bus_a.regs_out[23:12]), 32'h034);
        repeat (4) tick();

        // Multiply hold, observed on the DUT without RAW stalls.
        drive(16'hF321, 1'b1, 1'b0);
        tick();
        drive(16'h1234, 1'b1, 1'b0);
        chk("mul_busy_e1", 32'(bus_b.mul_busy), 32'h1);
        chk("mul_stall_e1", 32'(bus_b.stall), 32'h1);
        chk("mul_s1_e1", 32'(bus_b.ctrl_out[31:16]), 32'h7D04);
        for (int e = 2; e <= 4; e++) begin
            tick();
            chk("mul_busy", 32'(bus_b.mul_busy), (e < 4) ? 32'h1 : 32'h0);
            chk("mul_s2_bub", 32'(bus_b.valid_out[2]), 32'h0);
            chk("mul_s1_hold", 32'(bus_b.ctrl_out[31:16]), 32'h7D04);
        end
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        chk("mul_s1_next", 32'(bus_b.ctrl_out[31:16]), 32'h0906);
        chk("mul_s2_mul",  32'(bus_b.ctrl_out[47:32]), 32'h7D04);
        repeat (8) tick();

        // Flush with a jump in stage 2 and a younger op in stage 1.
        drive(16'hB123, 1'b1, 1'b0);
        tick();
        drive(16'h1234, 1'b1, 1'b0);
        tick();
        drive(16'h2345, 1'b1, 1'b1);
        chk("fl_s0_vld",  32'(bus_a.valid_out[0]), 32'h0);
        chk("fl_s0_ctrl", 32'(bus_a.ctrl_out[15:0]), 32'h0);
        chk("fl_stall",   32'(bus_a.stall), 32'h0);
        chk("fl_pre_s1",  32'(bus_a.ctrl_out[31:16]), 32'h0906);
        chk("fl_pre_s2",  32'(bus_a.ctrl_out[47:32]), 32'h5896);
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        chk("fl_vld12",  32'(bus_a.valid_out[2:1]), 32'h0);
        chk("fl_ctrl12", 32'(bus_a.ctrl_out[47:16]), 32'h0);
        chk("fl_regs12", 32'(bus_a.regs_out[35:12]), 32'h0);
        repeat (3) tick();

        // Flush while a mul occupies stage 1.
        drive(16'hF321, 1'b1, 1'b0);
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        chk("flm_busy_pre", 32'(bus_a.mul_busy), 32'h1);
        drive(16'h0000, 1'b0, 1'b1);
        chk("flm_stall", 32'(bus_a.stall), 32'h0);
        tick();
        drive(16'h0000, 1'b0, 1'b0);
        chk("flm_busy_post", 32'(bus_a.mul_busy), 32'h0);
        chk("flm_s1_vld",    32'(bus_a.valid_out[1]), 32'h0);
        repeat (3) tick();

        // Asynchronous reset in the middle of a mul.
        drive(16'hF321, 1'b1, 1'b0);
        tick();
        drive(16'h1234, 1'b1, 1'b0);
        chk("ar_busy_pre", 32'(bus_a.mul_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("ar_vld",   32'(bus_a.valid_out[2:1]), 32'h0);
        chk("ar_ctrl",  32'(bus_a.ctrl_out[47:16]), 32'h0);
        chk("ar_regs",  32'(bus_a.regs_out[35:12]), 32'h0);
        chk("ar_busy",  32'(bus_a.mul_busy), 32'h0);
        chk("ar_stall", 32'(bus_a.stall), 32'h0);
        tick();
        rst_n = 1'b1;
        drive(16'h0000, 1'b0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
